// File: rtl/gb_pkg.sv
// gb_pkg
// Shared constants, state encoding and helper functions for the gray_balance
// input decoder (gb_decode) and its control-packet parser (gb_ctrl_parse).
package gb_pkg;

  // Avalon-ST Video packet type codes carried in the low nibble of the header
  localparam logic [3:0] TYPE_CTRL  = 4'hF;
  localparam logic [3:0] TYPE_VIDEO = 4'h0;

  // Width, height and interlace nibbles of a control packet
  localparam int NUM_NIBBLES = 9;
  localparam int SHADOW_W    = 4 * NUM_NIBBLES;

  // One-hot decoder states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_CTRL  = 4'b0010,
    ST_VIDEO = 4'b0100,
    ST_DROP  = 4'b1000
  } state_t;

  // Beats needed to carry all nine nibbles for a given number of planes
  function automatic int ctrl_beats(input int planes);
    case (planes)
      1:       return 9;
      2:       return 5;
      default: return 3;
    endcase
  endfunction

  // Nibble index table: bit position of nibble k inside the shadow word
  // {width, height, interlaced}; nibble 0 is width[15:12] (the MSBs)
  function automatic int nibble_lsb(input int k);
    return 4 * (NUM_NIBBLES - 1 - k);
  endfunction

endpackage

// File: rtl/gb_ctrl_parse.sv
// gb_ctrl_parse
// Assembles the nine nibbles of a control packet into a shadow register and
// commits them to the visible width/height/interlace outputs on request.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             new packet header seen: discard any pending shadow
//   beat_en           a control payload beat is being transferred
//   commit            the current payload beat is the EOP of the packet
//   beat_data         payload beat (nibble per plane in bits [3:0] of plane)
//   video_width       last committed width
//   video_height      last committed height
//   video_interlaced  last committed interlace nibble
//   ctrl_update       one-cycle pulse after a successful commit
module gb_ctrl_parse
  import gb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_BITS   = 8,
  parameter int DATA_PLANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  beat_en,
  input  logic                  commit,
  input  logic [DATA_WIDTH-1:0] beat_data,
  output logic [15:0]           video_width,
  output logic [15:0]           video_height,
  output logic [3:0]            video_interlaced,
  output logic                  ctrl_update
);

  localparam int CTRL_BEATS = ctrl_beats(DATA_PLANES);

  logic [3:0]          beat_cnt;
  logic [3:0]          beat_cnt_next;
  logic [SHADOW_W-1:0] shadow;
  logic [SHADOW_W-1:0] shadow_next;
  logic                frame_complete;
  logic                unused_data;

  // Only the low nibble of each plane carries control information
  assign unused_data = ^beat_data;

  // Shadow value including the beat being transferred this cycle, so the EOP
  // beat's own nibbles are part of what gets committed. Beats beyond the
  // required count are ignored.
  always_comb begin
    shadow_next   = shadow;
    beat_cnt_next = beat_cnt;
    if (beat_en && (int'(beat_cnt) < CTRL_BEATS)) begin
      for (int p = 0; p < DATA_PLANES; p++) begin
        if (int'(beat_cnt) * DATA_PLANES + p < NUM_NIBBLES) begin
          shadow_next[nibble_lsb(int'(beat_cnt) * DATA_PLANES + p) +: 4] =
            beat_data[DATA_BITS*p +: 4];
        end
      end
      beat_cnt_next = beat_cnt + 4'd1;
    end
  end

  assign frame_complete = (int'(beat_cnt_next) >= CTRL_BEATS);

  // Shadow/commit registers; an incomplete packet leaves the outputs alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt         <= '0;
      shadow           <= '0;
      video_width      <= '0;
      video_height     <= '0;
      video_interlaced <= '0;
      ctrl_update      <= 1'b0;
    end else begin
      ctrl_update <= 1'b0;
      if (clear) begin
        beat_cnt <= '0;
        shadow   <= '0;
      end else begin
        beat_cnt <= beat_cnt_next;
        shadow   <= shadow_next;
        if (commit) begin
          beat_cnt <= '0;
          if (frame_complete) begin
            video_width      <= shadow_next[SHADOW_W-1 -: 16];
            video_height     <= shadow_next[SHADOW_W-17 -: 16];
            video_interlaced <= shadow_next[3:0];
            ctrl_update      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/gb_decode.sv
// gb_decode
// Avalon-ST Video packet decoder at the head of the gray_balance pipeline.
// Control packets update the frame geometry, video packets are forwarded
// without their header (zero latency), all other packets are consumed.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   din_*                 Avalon-ST Video input (data/valid/sop/eop/ready)
//   dout_*                pixel stream output (data/valid/sop/eop/ready)
//   video_width/height    last committed frame geometry
//   video_interlaced      last committed interlace nibble
//   ctrl_update           one-cycle pulse when a control packet commits
//   size_err              one-cycle pulse when a frame's pixel count differs
//                         from width*height
module gb_decode
  import gb_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_BITS   = 8,
  parameter int DATA_PLANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  input  logic                  dout_ready,
  output logic [15:0]           video_width,
  output logic [15:0]           video_height,
  output logic [3:0]            video_interlaced,
  output logic                  ctrl_update,
  output logic                  size_err
);

  state_t      state;
  state_t      state_next;
  logic        xfer;
  logic        hdr;
  logic        fwd;
  logic [3:0]  hdr_type;
  logic        first_pix;
  logic [31:0] pix_cnt;
  logic [31:0] pix_cnt_inc;
  logic [31:0] frame_size;

  assign xfer     = din_valid & din_ready;
  // Any SOP is a header, even when the previous packet never saw its EOP
  assign hdr      = xfer & din_startofpacket;
  assign fwd      = xfer & ~din_startofpacket & (state == ST_VIDEO);
  assign hdr_type = din_data[3:0];

  assign pix_cnt_inc = (&pix_cnt) ? pix_cnt : pix_cnt + 32'd1;
  assign frame_size  = {16'd0, video_width} * {16'd0, video_height};

  // Next-state decode; a header that is also EOP is an empty packet
  always_comb begin
    state_next = state;
    if (hdr) begin
      if (din_endofpacket)              state_next = ST_IDLE;
      else if (hdr_type == TYPE_CTRL)   state_next = ST_CTRL;
      else if (hdr_type == TYPE_VIDEO)  state_next = ST_VIDEO;
      else                              state_next = ST_DROP;
    end else if (xfer && din_endofpacket) begin
      state_next = ST_IDLE;
    end
  end

  // Stream outputs: only VIDEO connects input to output, everything else is
  // swallowed with ready held high
  always_comb begin
    din_ready          = 1'b1;
    dout_data          = din_data;
    dout_valid         = 1'b0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;
    if (state == ST_VIDEO) begin
      din_ready          = dout_ready;
      dout_valid         = din_valid & ~din_startofpacket;
      dout_startofpacket = first_pix;
      dout_endofpacket   = din_endofpacket;
    end
  end

  // State, first-pixel flag and saturating pixel counter; the size check
  // uses the count including the EOP beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      first_pix <= 1'b0;
      pix_cnt   <= '0;
      size_err  <= 1'b0;
    end else begin
      state    <= state_next;
      size_err <= 1'b0;
      if (hdr) begin
        first_pix <= (state_next == ST_VIDEO);
        if (state_next == ST_VIDEO) begin
          pix_cnt <= '0;
        end
      end else if (fwd) begin
        first_pix <= 1'b0;
        pix_cnt   <= pix_cnt_inc;
        if (din_endofpacket) begin
          size_err <= (pix_cnt_inc != frame_size);
        end
      end
    end
  end

  gb_ctrl_parse #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_BITS   (DATA_BITS),
    .DATA_PLANES (DATA_PLANES)
  ) u_ctrl_parse (
    .clk              (clk),
    .rst              (rst),
    .clear            (hdr),
    .beat_en          (xfer & ~din_startofpacket & (state == ST_CTRL)),
    .commit           (xfer & ~din_startofpacket & (state == ST_CTRL) & din_endofpacket),
    .beat_data        (din_data),
    .video_width      (video_width),
    .video_height     (video_height),
    .video_interlaced (video_interlaced),
    .ctrl_update      (ctrl_update)
  );

endmodule

// File: tb/tb_gb_decode.sv
// tb_gb_decode
// Directed bench for gb_decode: one single-plane instance (a_*) and one
// three-plane instance (b_*). Expected pixels are queued when driven and
// popped when the single-plane instance presents them.
module tb_gb_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Single-plane instance
  logic [7:0]  a_din_data = '0;
  logic        a_din_valid = 1'b0, a_din_sop = 1'b0, a_din_eop = 1'b0;
  logic        a_din_ready;
  logic [7:0]  a_dout_data;
  logic        a_dout_valid, a_dout_sop, a_dout_eop;
  logic        a_dout_ready = 1'b1;
  logic [15:0] a_width, a_height;
  logic [3:0]  a_il;
  logic        a_upd, a_serr;

  // Three-plane instance
  logic [23:0] b_din_data = '0;
  logic        b_din_valid = 1'b0, b_din_sop = 1'b0, b_din_eop = 1'b0;
  logic        b_din_ready;
  logic [23:0] b_dout_data_unused;
  logic        b_dout_valid, b_dout_sop_unused, b_dout_eop_unused;
  logic [15:0] b_width, b_height;
  logic [3:0]  b_il;
  logic        b_upd, b_serr;

  int vectors = 0;
  int miscompares = 0;
  logic [9:0] a_sb[$];
  int a_upd_cnt = 0, a_err_cnt = 0, a_pix_cnt = 0, a_stray = 0;
  int b_upd_cnt = 0, b_err_cnt = 0, b_pix_cnt = 0;
  bit vid_phase = 0, drop_phase = 0, bp_en = 0;

  gb_decode #(.DATA_WIDTH(8), .DATA_BITS(8), .DATA_PLANES(1)) dut_a (
    .clk(clk), .rst(rst),
    .din_data(a_din_data), .din_valid(a_din_valid),
    .din_startofpacket(a_din_sop), .din_endofpacket(a_din_eop),
    .din_ready(a_din_ready),
    .dout_data(a_dout_data), .dout_valid(a_dout_valid),
    .dout_startofpacket(a_dout_sop), .dout_endofpacket(a_dout_eop),
    .dout_ready(a_dout_ready),
    .video_width(a_width), .video_height(a_height), .video_interlaced(a_il),
    .ctrl_update(a_upd), .size_err(a_serr)
  );

  gb_decode #(.DATA_WIDTH(24), .DATA_BITS(8), .DATA_PLANES(3)) dut_b (
    .clk(clk), .rst(rst),
    .din_data(b_din_data), .din_valid(b_din_valid),
    .din_startofpacket(b_din_sop), .din_endofpacket(b_din_eop),
    .din_ready(b_din_ready),
    .dout_data(b_dout_data_unused), .dout_valid(b_dout_valid),
    .dout_startofpacket(b_dout_sop_unused), .dout_endofpacket(b_dout_eop_unused),
    .dout_ready(1'b1),
    .video_width(b_width), .video_height(b_height), .video_interlaced(b_il),
    .ctrl_update(b_upd), .size_err(b_serr)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Random downstream backpressure, changed away from the sampling edge
  always @(posedge clk) begin
    if (bp_en) begin
      #2;
      a_dout_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor and scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (a_upd) a_upd_cnt++;
      if (a_serr) a_err_cnt++;
      if (b_upd) b_upd_cnt++;
      if (b_serr) b_err_cnt++;
      if (b_dout_valid) b_pix_cnt++;
      if (drop_phase && (a_dout_valid || !a_din_ready)) a_stray++;
      if (vid_phase) check_output("ready_track", 32'(a_din_ready), 32'(a_dout_ready));
      if (a_dout_valid && a_dout_ready) begin
        a_pix_cnt++;
        check_output("sb_has_entry", 32'(a_sb.size() != 0), 32'd1);
        if (a_sb.size() != 0)
          check_output("pixel", 32'({a_dout_sop, a_dout_eop, a_dout_data}), 32'(a_sb.pop_front()));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic s, input logic e);
    bit ok = 0;
    int guard = 0;
    a_din_data = d; a_din_valid = 1'b1; a_din_sop = s; a_din_eop = e;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = a_din_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    a_din_valid = 1'b0; a_din_sop = 1'b0; a_din_eop = 1'b0;
    if (!ok) check_output("a_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_b(input logic [23:0] d, input logic s, input logic e);
    bit ok = 0;
    int guard = 0;
    b_din_data = d; b_din_valid = 1'b1; b_din_sop = s; b_din_eop = e;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = b_din_ready;
      @(posedge clk);
      guard++;
    end
    #1;
    b_din_valid = 1'b0; b_din_sop = 1'b0; b_din_eop = 1'b0;
    if (!ok) check_output("b_handshake_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [3:0] nib_of(input logic [35:0] nibs, input int k);
    logic [3:0] n;
    n = 4'h7;
    if (k < 9) n = nibs[35-4*k -: 4];
    return n;
  endfunction

  // Control packet on the single-plane instance; junk in the upper nibble
  task automatic apply_stimulus_a_ctrl(input logic [35:0] nibs, input int count);
    send_a({4'($urandom_range(0, 15)), 4'hF}, 1'b1, 1'b0);
    for (int k = 0; k < count; k++)
      send_a({4'($urandom_range(0, 15)), nib_of(nibs, k)}, 1'b0, k == count - 1);
  endtask

  // Video frame on the single-plane instance, expected pixels queued
  task automatic apply_stimulus_a_video(input int n, input bit close);
    logic [7:0] d;
    send_a({4'($urandom_range(0, 15)), 4'h0}, 1'b1, 1'b0);
    vid_phase = 1;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      a_sb.push_back({i == 0, close && (i == n - 1), d});
      send_a(d, 1'b0, close && (i == n - 1));
    end
    vid_phase = 0;
  endtask

  // Control packet on the three-plane instance
  task automatic apply_stimulus_b_ctrl(input logic [35:0] nibs, input int beats);
    send_b(24'h00000F, 1'b1, 1'b0);
    for (int j = 0; j < beats; j++)
      send_b({4'hC, nib_of(nibs, 3*j+2), 4'h5, nib_of(nibs, 3*j+1), 4'hA, nib_of(nibs, 3*j)},
             1'b0, j == beats - 1);
  endtask

  task automatic apply_stimulus_b_video(input int n);
    send_b(24'hABCD00, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) send_b(24'($urandom), 1'b0, i == n - 1);
  endtask

  initial begin
    #200000;
    check_output("watchdog", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_width", 32'(a_width), 32'd0);
    check_output("rst_height", 32'(a_height), 32'd0);
    check_output("rst_il", 32'(a_il), 32'd0);
    check_output("rst_din_ready", 32'(a_din_ready), 32'd1);
    check_output("rst_dout_valid", 32'(a_dout_valid), 32'd0);
    check_output("rst_ctrl_update", 32'(a_upd), 32'd0);
    check_output("rst_size_err", 32'(a_serr), 32'd0);
    check_output("rst_b_width", 32'(b_width), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(1);

    // 640x480 interlace 3 control packet
    apply_stimulus_a_ctrl(36'h0280_01E0_3, 9);
    wait_cycles(2);
    check_output("t1_width", 32'(a_width), 32'h0280);
    check_output("t1_height", 32'(a_height), 32'h01E0);
    check_output("t1_il", 32'(a_il), 32'd3);
    check_output("t1_upd", 32'(a_upd_cnt), 32'd1);

    // 4x3 geometry with one surplus beat, then a matching 12-pixel frame
    apply_stimulus_a_ctrl(36'h0004_0003_1, 10);
    wait_cycles(2);
    check_output("t1b_width", 32'(a_width), 32'd4);
    check_output("t1b_height", 32'(a_height), 32'd3);
    check_output("t1b_il", 32'(a_il), 32'd1);
    check_output("t1b_upd", 32'(a_upd_cnt), 32'd2);
    apply_stimulus_a_video(12, 1);
    wait_cycles(2);
    check_output("t1b_sb_empty", 32'(a_sb.size()), 32'd0);
    check_output("t1b_pixels", 32'(a_pix_cnt), 32'd12);
    check_output("t1b_size_err", 32'(a_err_cnt), 32'd0);

    // Short control packet: five nibbles only
    apply_stimulus_a_ctrl(36'h0FFF_0FFF_F, 5);
    wait_cycles(2);
    check_output("t3_width", 32'(a_width), 32'd4);
    check_output("t3_height", 32'(a_height), 32'd3);
    check_output("t3_upd", 32'(a_upd_cnt), 32'd2);

    // Unknown packet type 0x5, 20 payload beats
    send_a(8'h25, 1'b1, 1'b0);
    drop_phase = 1;
    for (int i = 0; i < 20; i++) send_a(8'($urandom), 1'b0, i == 19);
    drop_phase = 0;
    wait_cycles(2);
    check_output("t4_stray", 32'(a_stray), 32'd0);
    check_output("t4_pixels", 32'(a_pix_cnt), 32'd12);
    check_output("t4_width", 32'(a_width), 32'd4);

    // 7-pixel frame against 4x3 geometry
    apply_stimulus_a_video(7, 1);
    wait_cycles(2);
    check_output("t2_size_err", 32'(a_err_cnt), 32'd1);
    check_output("t2_sb_empty", 32'(a_sb.size()), 32'd0);

    // 10x10 frame under random backpressure
    apply_stimulus_a_ctrl(36'h000A_000A_0, 9);
    wait_cycles(2);
    check_output("t5_upd", 32'(a_upd_cnt), 32'd3);
    bp_en = 1;
    apply_stimulus_a_video(100, 1);
    bp_en = 0;
    wait_cycles(1);
    a_dout_ready = 1'b1;
    wait_cycles(2);
    check_output("t5_sb_empty", 32'(a_sb.size()), 32'd0);
    check_output("t5_pixels", 32'(a_pix_cnt), 32'd119);
    check_output("t5_size_err", 32'(a_err_cnt), 32'd1);

    // Reset in the middle of a frame
    apply_stimulus_a_video(5, 0);
    rst = 1'b1;
    @(negedge clk);
    check_output("t6_width", 32'(a_width), 32'd0);
    check_output("t6_height", 32'(a_height), 32'd0);
    check_output("t6_din_ready", 32'(a_din_ready), 32'd1);
    check_output("t6_dout_valid", 32'(a_dout_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(1);
    drop_phase = 1;
    for (int i = 0; i < 3; i++) send_a(8'h11 + 8'(i), 1'b0, i == 2);
    drop_phase = 0;
    apply_stimulus_a_video(3, 1);
    wait_cycles(2);
    check_output("t6_stray", 32'(a_stray), 32'd0);
    check_output("t6_sb_empty", 32'(a_sb.size()), 32'd0);
    check_output("t6_pixels", 32'(a_pix_cnt), 32'd127);
    check_output("t6_size_err", 32'(a_err_cnt), 32'd2);
    check_output("t6_upd", 32'(a_upd_cnt), 32'd3);

    // Three-plane instance
    apply_stimulus_b_ctrl(36'h0280_01E0_3, 3);
    wait_cycles(2);
    check_output("b_width", 32'(b_width), 32'h0280);
    check_output("b_height", 32'(b_height), 32'h01E0);
    check_output("b_il", 32'(b_il), 32'd3);
    check_output("b_upd", 32'(b_upd_cnt), 32'd1);
    apply_stimulus_b_ctrl(36'h0004_0002_0, 3);
    wait_cycles(2);
    check_output("b_width2", 32'(b_width), 32'd4);
    check_output("b_height2", 32'(b_height), 32'd2);
    check_output("b_il2", 32'(b_il), 32'd0);
    apply_stimulus_b_ctrl(36'h0FFF_0FFF_F, 2);
    wait_cycles(2);
    check_output("b_short_width", 32'(b_width), 32'd4);
    check_output("b_short_upd", 32'(b_upd_cnt), 32'd2);
    apply_stimulus_b_video(8);
    wait_cycles(2);
    check_output("b_pixels8", 32'(b_pix_cnt), 32'd8);
    check_output("b_size_ok", 32'(b_err_cnt), 32'd0);
    apply_stimulus_b_video(7);
    wait_cycles(2);
    check_output("b_pixels15", 32'(b_pix_cnt), 32'd15);
    check_output("b_size_err", 32'(b_err_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
